// File: rtl/yadan_muldiv_pkg.sv
// yadan_muldiv_pkg: shared encodings for the RV32M multiply/divide unit.
// Op and signedness encodings match the EX-stage request fields.
// FSM state encoding and the iteration count live here as well.
package yadan_muldiv_pkg;

  // Operation select on mul_or_div_i
  localparam logic MUL = 1'b0;
  localparam logic DIV = 1'b1;

  // Operand signedness on reg*_signed0_unsigned1_i
  localparam logic Signed   = 1'b0;
  localparam logic Unsigned = 1'b1;

  // One result bit per cycle, one cycle per operand bit
  localparam int MulDivIter = 32;

  typedef logic [63:0] DoubleRegBus;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/yadan_muldiv_signfix.sv
// yadan_muldiv_signfix: conditional two's-complement negation, per half or full width.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module yadan_muldiv_signfix #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_val,
  input  logic              i_wide,
  input  logic              i_neg_hi,
  input  logic              i_neg_lo,
  output logic [2*XLEN-1:0] o_val
);

  logic [2*XLEN-1:0] w_wide;
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;

  // Wide mode negates the whole 64-bit value (product); split mode treats each half independently
  always_comb begin
    w_wide = i_neg_lo ? -i_val : i_val;
    w_hi   = i_neg_hi ? -i_val[2*XLEN-1:XLEN] : i_val[2*XLEN-1:XLEN];
    w_lo   = i_neg_lo ? -i_val[XLEN-1:0] : i_val[XLEN-1:0];
    o_val  = i_wide ? w_wide : {w_hi, w_lo};
  end

endmodule

// File: rtl/yadan_muldiv.sv
// yadan_muldiv: iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit beside ex.
// Latency: done_o in the 34th cycle after acceptance; 2nd cycle for divide-by-zero (and MUL with MULDIV_FAST_MUL_EN).
// Backpressure: start_i is a held level; dropping it in CALC/FIX aborts, start_i during DONE is ignored.
module yadan_muldiv
  import yadan_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              mul_or_div_i,
  input  logic              reg1_signed0_unsigned1_i,
  input  logic              reg2_signed0_unsigned1_i,
  input  logic [XLEN-1:0]   dividend_i,
  input  logic [XLEN-1:0]   divisor_i,
  output logic [2*XLEN-1:0] result_o,
  output logic              done_o,
  output logic              busy_o
);

  localparam int CW = $clog2(MulDivIter);

  state_t            r_state;
  state_t            w_next;
  logic              r_op;
  logic              r_neg_a;
  logic              r_neg_b;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_a;      // shifting multiplicand (MUL)
  logic [XLEN-1:0]   r_b;      // shifting multiplier (MUL) / divisor magnitude (DIV)
  logic [2*XLEN-1:0] r_acc;    // product (MUL) / {remainder, quotient} (DIV)
  logic [2*XLEN-1:0] r_result;

  logic              w_neg_a;
  logic              w_neg_b;
  logic              w_div_zero;
  logic              w_fast_mul;
  logic [2*XLEN-1:0] w_mag;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_res_in;
  logic [2*XLEN-1:0] w_res;
  logic              w_res_wide;

`ifdef MULDIV_FAST_MUL_EN
  assign w_fast_mul = 1'b1;
`else
  assign w_fast_mul = 1'b0;
`endif

  assign w_neg_a    = (reg1_signed0_unsigned1_i == Signed) && dividend_i[XLEN-1];
  assign w_neg_b    = (reg2_signed0_unsigned1_i == Signed) && divisor_i[XLEN-1];
  assign w_div_zero = (mul_or_div_i == DIV) && (divisor_i == '0);

  // Operand magnitudes: each half negated independently when signed-negative
  yadan_muldiv_signfix #(.XLEN(XLEN)) u_opnd_fix (
    .i_val    ({dividend_i, divisor_i}),
    .i_wide   (1'b0),
    .i_neg_hi (w_neg_a),
    .i_neg_lo (w_neg_b),
    .o_val    (w_mag)
  );
  assign w_mag_a = w_mag[2*XLEN-1:XLEN];
  assign w_mag_b = w_mag[XLEN-1:0];

  // Restoring divide step: shift next dividend bit into the partial remainder, subtract if it fits
  assign w_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_ge    = ~w_diff[XLEN];

  // Result sign fix: product negated as one 64-bit value; quotient/remainder negated per half.
  // Divide-by-zero clears both sign flags so its raw result passes untouched.
  assign w_res_wide = (r_op == MUL);
  assign w_res_in   = (r_op == MUL) ? r_acc : {r_acc[XLEN-1:0], r_acc[2*XLEN-1:XLEN]};
  yadan_muldiv_signfix #(.XLEN(XLEN)) u_res_fix (
    .i_val    (w_res_in),
    .i_wide   (w_res_wide),
    .i_neg_hi (r_neg_a ^ r_neg_b),
    .i_neg_lo ((r_op == MUL) ? (r_neg_a ^ r_neg_b) : r_neg_a),
    .o_val    (w_res)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: accept in IDLE, abort on start_i low in CALC/FIX, DONE always returns to IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (mul_or_div_i == DIV) w_next = w_div_zero ? S_FIX : S_CALC;
          else                     w_next = w_fast_mul ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (!start_i)                             w_next = S_IDLE;
        else if (r_cnt == CW'(MulDivIter - 1)) w_next = S_FIX;
      end
      S_FIX:  w_next = start_i ? S_DONE : S_IDLE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch magnitudes on accept, iterate in CALC, register the signed result in FIX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= MUL;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_op    <= mul_or_div_i;
            r_cnt   <= '0;
            r_neg_a <= w_neg_a & ~w_div_zero;
            r_neg_b <= w_neg_b & ~w_div_zero;
            r_a     <= {{XLEN{1'b0}}, w_mag_a};
            r_b     <= w_mag_b;
            if (w_div_zero) begin
              r_acc <= {dividend_i, {XLEN{1'b1}}};
            end else if (mul_or_div_i == DIV) begin
              r_acc <= {{XLEN{1'b0}}, w_mag_a};
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              r_acc <= {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
`else
              r_acc <= '0;
`endif
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op == MUL) begin
            if (r_b[0]) r_acc <= r_acc + r_a;
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
          end else begin
            r_acc <= {(w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
          end
        end
        S_FIX: begin
          if (start_i) r_result <= w_res;
        end
        default: ;
      endcase
    end
  end

  assign result_o = r_result;
  assign done_o   = (r_state == S_DONE);
  assign busy_o   = (r_state == S_CALC) || (r_state == S_FIX);

endmodule

// File: tb/tb_yadan_muldiv.sv
// tb_yadan_muldiv: directed vectors for the multiply/divide unit.
// Checks result, done latency, single-cycle done, flush abort and asynchronous reset.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_yadan_muldiv;
  import yadan_muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int DZ_LAT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        mul_or_div_i = MUL;
  logic        reg1_signed0_unsigned1_i = Unsigned;
  logic        reg2_signed0_unsigned1_i = Unsigned;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  DoubleRegBus result_o;
  logic        done_o;
  logic        busy_o;

  int tests = 0;
  int fails = 0;
  bit seen;

  yadan_muldiv #(.XLEN(32)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .start_i                  (start_i),
    .mul_or_div_i             (mul_or_div_i),
    .reg1_signed0_unsigned1_i (reg1_signed0_unsigned1_i),
    .reg2_signed0_unsigned1_i (reg2_signed0_unsigned1_i),
    .dividend_i               (dividend_i),
    .divisor_i                (divisor_i),
    .result_o                 (result_o),
    .done_o                   (done_o),
    .busy_o                   (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Called at a falling edge with the unit idle; drives one request and holds it until done_o.
  task automatic run_op(input string tag, input logic op, input logic s1, input logic s2,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] want, input int want_lat);
    int  n;
    bit  got_done;
    start_i = 1'b1;
    mul_or_div_i = op;
    reg1_signed0_unsigned1_i = s1;
    reg2_signed0_unsigned1_i = s2;
    dividend_i = a;
    divisor_i = b;
    n = 0;
    got_done = 1'b0;
    while (!got_done && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) check64({tag, " busy"}, {63'd0, busy_o}, 64'd1);
      if (n == 2) begin
        // Operands scrambled while busy must not affect the latched request
        dividend_i = a ^ 32'hDEAD_BEEF;
        divisor_i  = b ^ 32'h1357_9BDF;
      end
      if (done_o) got_done = 1'b1;
    end
    check_int({tag, " done seen"}, int'(got_done), 1);
    check_int({tag, " latency"}, n, want_lat);
    check64({tag, " result"}, result_o, want);
    start_i = 1'b0;
    @(negedge clk);
    check64({tag, " done one cycle"}, {63'd0, done_o}, 64'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check64("reset result", result_o, 64'd0);
    check64("reset done", {63'd0, done_o}, 64'd0);
    check64("reset busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("mulu 7x6",        MUL, Unsigned, Unsigned, 32'd7,          32'd6,          64'h0000_0000_0000_002A, MUL_LAT);
    run_op("mulh -1x-1",      MUL, Signed,   Signed,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001, MUL_LAT);
    run_op("mulhsu -1xmax",   MUL, Signed,   Unsigned, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFF_0000_0001, MUL_LAT);
    run_op("mulhu maxxmax",   MUL, Unsigned, Unsigned, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, MUL_LAT);
    run_op("div -7/2",        DIV, Signed,   Signed,   32'hFFFF_FFF9,  32'd2,          64'hFFFF_FFFD_FFFF_FFFF, DIV_LAT);
    run_op("div 7/-2",        DIV, Signed,   Signed,   32'd7,          32'hFFFF_FFFE,  64'hFFFF_FFFD_0000_0001, DIV_LAT);
    run_op("divu 100/7",      DIV, Unsigned, Unsigned, 32'd100,        32'd7,          64'h0000_000E_0000_0002, DIV_LAT);
    run_op("divu x/0",        DIV, Unsigned, Unsigned, 32'h1234_5678,  32'd0,          64'hFFFF_FFFF_1234_5678, DZ_LAT);
    run_op("div neg/0",       DIV, Signed,   Signed,   32'h8000_0005,  32'd0,          64'hFFFF_FFFF_8000_0005, DZ_LAT);
    run_op("div ovf",         DIV, Signed,   Signed,   32'h8000_0000,  32'hFFFF_FFFF,  64'h8000_0000_0000_0000, DIV_LAT);
    run_op("mulu 2^16x2^16",  MUL, Unsigned, Unsigned, 32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, MUL_LAT);

    // Flush: drop start_i during CALC cycle 10 of a divide
    start_i = 1'b1;
    mul_or_div_i = DIV;
    reg1_signed0_unsigned1_i = Unsigned;
    reg2_signed0_unsigned1_i = Unsigned;
    dividend_i = 32'd1000;
    divisor_i = 32'd3;
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check64("flush busy before", {63'd0, busy_o}, 64'd1);
    start_i = 1'b0;
    @(negedge clk);
    check64("flush busy after", {63'd0, busy_o}, 64'd0);
    for (int c = 0; c < 4; c++) begin
      if (done_o) seen = 1'b1;
      @(negedge clk);
    end
    check_int("flush no done", int'(seen), 0);
    check64("flush result kept", result_o, 64'h0000_0001_0000_0000);
    run_op("mulu 3x3 after flush", MUL, Unsigned, Unsigned, 32'd3, 32'd3, 64'h0000_0000_0000_0009, MUL_LAT);

    // Asynchronous reset in the middle of a divide
    start_i = 1'b1;
    mul_or_div_i = DIV;
    dividend_i = 32'd1000;
    divisor_i = 32'd3;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    check64("pre-reset busy", {63'd0, busy_o}, 64'd1);
    rst = 1'b1;
    #1;
    check64("async rst result", result_o, 64'd0);
    check64("async rst busy", {63'd0, busy_o}, 64'd0);
    check64("async rst done", {63'd0, done_o}, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check_int("post-reset no done", int'(seen), 0);
    run_op("divu 1000/3 after reset", DIV, Unsigned, Unsigned, 32'd1000, 32'd3, 64'h0000_014D_0000_0001, DIV_LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/yadan_muldiv.md
Name: yadan_muldiv

Overview:
Iterative multiply/divide unit that services the EX-stage mul/div request interface. It implements RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. EX holds `start` high combinationally while an M-extension instruction sits in EX without `done`. The unit returns a 64-bit packed result with a one-cycle `done_o` pulse. It sits beside `ex`, sharing the core clock and reset.

Parameters:
XLEN, 32, operand width; result width is 2*XLEN.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
start_i  input  1  request level from EX; held until done_o or flush
mul_or_div_i  input  1  `MUL / `DIV (yadan_defs.v encodings)
reg1_signed0_unsigned1_i  input  1  operand-1 signedness, `Signed=0 / `Unsigned=1
reg2_signed0_unsigned1_i  input  1  operand-2 signedness
dividend_i  input  XLEN  operand 1 (multiplicand or dividend)
divisor_i  input  XLEN  operand 2 (multiplier or divisor)
result_o  output  2*XLEN  MUL: full product {hi, lo}; DIV: {quotient, remainder}
done_o  output  1  one-cycle completion pulse; result_o valid in the same cycle
busy_o  output  1  high while a request is accepted and not yet done or aborted

Reset and clocking:
- One clock; reset is asynchronous and active-high, ports named `clk` and `rst`.
- On `rst`, outputs clear immediately: result_o=0, done_o=0, busy_o=0, FSM=IDLE.
- Reset mid-operation discards all state; no done_o is produced.

State machine: IDLE, CALC, FIX, DONE.
- IDLE: start_i=1 at an edge latches the operands, their signedness and the op. It computes absolute values of any operand flagged signed with MSB=1, records the result sign, clears counter/accumulators and enters CALC. busy_o goes high the next cycle.
- IDLE, divisor zero (DIV only): bypass CALC, go to FIX with quotient=all-ones, remainder=dividend_i (raw, unsigned-abs not applied).
- CALC, MUL: radix-2 shift-add, one multiplier bit per cycle, 32 cycles, unsigned 64-bit product of the magnitudes.
- CALC, DIV: restoring division, one quotient bit per cycle, 32 cycles, on magnitudes.
- FIX, MUL: negate the 64-bit product if exactly one operand was signed-negative.
- FIX, DIV: negate the quotient if operand signs differ; give the remainder the dividend's sign.
- FIX, overflow: signed DIV with -2^31 / -1 yields quotient 0x80000000, remainder 0, with no special path needed beyond two's-complement wrap.
- FIX registers result_o and goes to DONE.
- DONE: done_o=1 for exactly this cycle, busy_o=0, then return to IDLE.
- result_o holds its value until the next FIX. done_o is never asserted for two consecutive cycles.

Latency:
- Normal operation: done_o is high in the 34th cycle after the edge that accepted start_i.
- Divide-by-zero: done_o is high in the 2nd cycle after the accepting edge.

Abort (flush/interrupt):
- start_i low while in CALC or FIX returns to IDLE at the next edge.
- No done_o; result_o is unchanged.

Back-to-back requests:
- start_i seen in DONE is ignored. EX drops start combinationally on done.
- A new request is accepted in the following IDLE cycle.
- Operand changes while busy are ignored; latched copies are used.

Optional Feature:
- Macro `MULDIV_FAST_MUL_EN`.
- Defined: multiply skips CALC. IDLE computes the magnitude product with a single 32x32 `*` into the accumulator, then goes directly to FIX. MUL done_o arrives in the 2nd cycle after acceptance. Divide is unchanged.
- Undefined: iterative multiply as above, and no multiplier array is inferred.

Decomposition:
- yadan_defs.v gains `MUL`, `DIV`, `Signed`, `Unsigned` (if absent), `DoubleRegBus` [63:0], and `MulDivIter` = 32.
- FSM state encodings are local parameters.
- One natural sub-module, `yadan_muldiv_signfix`: combinational magnitude extraction and conditional 64-bit negation, instantiated once for the operand path and once for the result path.

Test Plan:
1. MUL 7 x 6, both `Unsigned` -> result_o=0x0000_0000_0000_002A, done_o high the 34th cycle after start, for one cycle only.
2. MULH signed 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0x0000_0000_0000_0001. MULHSU with the same operands -> result_o[63:32]=0xFFFFFFFF.
3. DIV signed -7 / 2 -> result_o={0xFFFFFFFD, 0xFFFFFFFF} (q=-3, r=-1). DIVU 100/7 -> {0x0000000E, 0x00000002}.
4. DIV x/0 with x=0x12345678 -> result_o={0xFFFFFFFF, 0x12345678}, done_o in cycle 2. Signed 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0x00000000}.
5. Flush: drop start_i at CALC cycle 10 -> no done_o, busy_o low next cycle, result_o unchanged. An immediate new MUL 3x3 -> 9 at normal latency.
6. Assert rst at CALC cycle 5 -> outputs zero without waiting for a clock edge. With `MULDIV_FAST_MUL_EN`, MUL 0x10000 x 0x10000 -> 0x0000_0001_0000_0000 with done_o in cycle 2.
